// File: rtl/lp_pkg.sv
// Shared definitions for the low-pass FIR path: sample queue FSM states and
// default tap count / sample width used by lp_sample_queue, LP_fir and its ROM.
package lp_pkg;

    localparam int unsigned LP_TAPS = 1021;
    localparam int unsigned SMPL_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ
    } lpq_state_e;

endpackage

// File: rtl/lpq_dpram.sv
// Simple dual-port RAM for the sample queue: synchronous write port and a
// registered read port (one-cycle latency) whose output register resets to 0.
module lpq_dpram #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 1021,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Array kept out of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/lp_sample_queue.sv
// Dual-channel circular queue of the last DEPTH sample pairs; streams all of
// them oldest-first to the FIR on each write to a full queue.
// Optional sticky overrun flag: define LPQ_OVERRUN_EN.
module lp_sample_queue
    import lp_pkg::*;
#(
    parameter int unsigned DEPTH = LP_TAPS,
    parameter int unsigned DW    = SMPL_W,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wrt_smpl,
    input  logic [DW-1:0] lft_smpl,
    input  logic [DW-1:0] rht_smpl,
    output logic          sequencing,
    output logic [DW-1:0] lft_out,
    output logic [DW-1:0] rht_out
`ifdef LPQ_OVERRUN_EN
    ,
    output logic          overrun
`endif
);

    localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    lpq_state_e state, state_nxt;

    logic [AW-1:0]   new_ptr, old_ptr, rd_ptr, rd_cnt;
    logic [AW:0]     cnt;
    logic            pend;
    logic [DW-1:0]   lft_q, rht_q;
    logic            full;
    logic            full_after_write;
    logic            ram_we, ram_re;
    logic [2*DW-1:0] rd_data;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign full             = (cnt == FULL_CNT);
    assign full_after_write = (cnt >= FULL_CNT - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (wrt_smpl || pend) state_nxt = WRITE;
            WRITE:   state_nxt = full_after_write ? READ : IDLE;
            READ:    if (rd_cnt == LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sequencing = (state == READ);
        ram_we     = (state == WRITE);
        ram_re     = (state == READ);
    end

    // A strobe is taken whenever no sample is already waiting; in IDLE that is
    // the direct path, elsewhere it becomes the pending sample. The capture
    // register therefore always holds the next sample WRITE will store.
    always_ff @(posedge clk) begin
        if (rst) begin
            new_ptr <= '0;
            old_ptr <= '0;
            rd_ptr  <= '0;
            rd_cnt  <= '0;
            cnt     <= '0;
            pend    <= 1'b0;
            lft_q   <= '0;
            rht_q   <= '0;
        end else begin
            if (wrt_smpl && !pend) begin
                lft_q <= lft_smpl;
                rht_q <= rht_smpl;
            end

            if (state == IDLE) begin
                pend <= 1'b0;
            end else if (wrt_smpl) begin
                pend <= 1'b1;
            end

            case (state)
                WRITE: begin
                    new_ptr <= wrap_inc(new_ptr);
                    rd_cnt  <= '0;
                    if (full) begin
                        old_ptr <= wrap_inc(old_ptr);
                        rd_ptr  <= wrap_inc(old_ptr);
                    end else begin
                        cnt    <= cnt + 1'b1;
                        rd_ptr <= old_ptr;
                    end
                end
                READ: begin
                    rd_ptr <= wrap_inc(rd_ptr);
                    rd_cnt <= rd_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef LPQ_OVERRUN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (wrt_smpl && pend) begin
            overrun <= 1'b1;
        end
    end
`endif

    lpq_dpram #(
        .W     (2 * DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (new_ptr),
        .wdata ({lft_q, rht_q}),
        .re    (ram_re),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    assign lft_out = rd_data[2*DW-1:DW];
    assign rht_out = rd_data[DW-1:0];

endmodule

// File: tb/tb_lp_sample_queue.sv
// Bench for lp_sample_queue: a DEPTH=8 and a default DEPTH=1021 instance,
// checked against a queue model of the last DEPTH sample pairs.
module tb_lp_sample_queue;

    localparam int unsigned D0 = 8;
    localparam int unsigned D1 = 1021;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, wrt0, sq0;
    logic [15:0] li0, ri0, lo0, ro0;
    logic        rst1, wrt1, sq1;
    logic [15:0] li1, ri1, lo1, ro1;
`ifdef LPQ_OVERRUN_EN
    logic        ov0, ov1;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];

    lp_sample_queue #(.DEPTH(D0), .DW(16), .AW(3)) dut0 (
        .clk(clk), .rst(rst0), .wrt_smpl(wrt0), .lft_smpl(li0), .rht_smpl(ri0),
        .sequencing(sq0), .lft_out(lo0), .rht_out(ro0)
`ifdef LPQ_OVERRUN_EN
        , .overrun(ov0)
`endif
    );

    lp_sample_queue #(.DEPTH(D1), .DW(16), .AW(10)) dut1 (
        .clk(clk), .rst(rst1), .wrt_smpl(wrt1), .lft_smpl(li1), .rht_smpl(ri1),
        .sequencing(sq1), .lft_out(lo1), .rht_out(ro1)
`ifdef LPQ_OVERRUN_EN
        , .overrun(ov1)
`endif
    );

    function automatic int unsigned depth_of(input int unsigned u);
        return (u == 0) ? D0 : D1;
    endfunction

    function automatic logic seq_of(input int unsigned u);
        return (u == 0) ? sq0 : sq1;
    endfunction

    function automatic logic [31:0] out_of(input int unsigned u);
        return (u == 0) ? {lo0, ro0} : {lo1, ro1};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        assert (obs === req) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic drive(input int unsigned u, input logic w, input logic [15:0] l, input logic [15:0] r);
        if (u == 0) begin
            wrt0 = w; li0 = l; ri0 = r;
        end else begin
            wrt1 = w; li1 = l; ri1 = r;
        end
    endtask

    task automatic set_rst(input int unsigned u, input logic v);
        if (u == 0) rst0 = v;
        else        rst1 = v;
    endtask

    task automatic model_push(input int unsigned u, input logic [31:0] s);
        if (u == 0) begin
            q0.push_back(s);
            if (q0.size() > D0) void'(q0.pop_front());
        end else begin
            q1.push_back(s);
            if (q1.size() > D1) void'(q1.pop_front());
        end
    endtask

    function automatic int unsigned model_size(input int unsigned u);
        return (u == 0) ? q0.size() : q1.size();
    endfunction

    task automatic model_clear(input int unsigned u);
        if (u == 0) q0.delete();
        else        q1.delete();
    endtask

    // Strobe one sample from an IDLE cycle; returns at R0 if that write fills the queue.
    task automatic write_smpl(input int unsigned u, input logic [15:0] l, input logic [15:0] r);
        drive(u, 1'b1, l, r);
        model_push(u, {l, r});
        @(posedge clk); #1;
        drive(u, 1'b0, 16'($urandom), 16'($urandom));
        @(negedge clk);
        chk("seq_in_write", {31'b0, seq_of(u)}, 32'd0);
        @(posedge clk); #1;
        if (model_size(u) < depth_of(u)) begin
            @(negedge clk);
            chk("seq_idle", {31'b0, seq_of(u)}, 32'd0);
        end
    endtask

    // Entered at R0. Strobes at cycle s1 (taken) / s2 (dropped); optional reset at rst_at.
    task automatic readout(input int unsigned u, input int s1, input int s2, input int rst_at,
                           output logic again);
        logic [31:0] exp_q[$];
        logic [31:0] smp;
        logic [31:0] held;
        logic        pended;
        int          d;
        d = int'(depth_of(u));
        if (u == 0) exp_q = q0;
        else        exp_q = q1;
        pended = 1'b0;
        again  = 1'b0;
        held   = '0;
        for (int c = 0; c <= d; c++) begin
            @(negedge clk);
            chk("seq_readout", {31'b0, seq_of(u)}, {31'b0, (c < d)});
            if (c >= 1) chk("stream", out_of(u), exp_q[c-1]);
            if (c == s1 || c == s2) begin
                smp = {16'($urandom), 16'($urandom)};
                drive(u, 1'b1, smp[31:16], smp[15:0]);
                if (c == s1) begin
                    pended = 1'b1;
                    held   = smp;
                end
            end
            if (c == rst_at) set_rst(u, 1'b1);
            @(posedge clk); #1;
            drive(u, 1'b0, 16'($urandom), 16'($urandom));
            if (c == rst_at) begin
                set_rst(u, 1'b0);
                @(negedge clk);
                chk("seq_after_rst", {31'b0, seq_of(u)}, 32'd0);
                chk("out_after_rst", out_of(u), 32'd0);
                model_clear(u);
                return;
            end
        end
        if (pended) begin
            model_push(u, held);
            @(negedge clk);
            chk("seq_pend_write", {31'b0, seq_of(u)}, 32'd0);
            @(posedge clk); #1;
            again = 1'b1;
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic again;
        int   s;
        rst0 = 1'b1; rst1 = 1'b1;
        drive(0, 1'b0, '0, '0);
        drive(1, 1'b1, 16'h1234, 16'h5678);  // strobe coincident with reset is ignored
        @(posedge clk); #1;
        @(posedge clk); #1;
        drive(1, 1'b0, '0, '0);
        @(negedge clk);
        chk("rst_seq0", {31'b0, sq0}, 32'd0);
        chk("rst_out0", {lo0, ro0}, 32'd0);
        chk("rst_seq1", {31'b0, sq1}, 32'd0);
        chk("rst_out1", {lo1, ro1}, 32'd0);
`ifdef LPQ_OVERRUN_EN
        chk("rst_ov0", {31'b0, ov0}, 32'd0);
        chk("rst_ov1", {31'b0, ov1}, 32'd0);
`endif
        rst0 = 1'b0; rst1 = 1'b0;

        // Fill 1..8, then wrap with 9 and 10.
        for (int i = 1; i <= 7; i++) write_smpl(0, 16'(i), 16'($urandom));
        write_smpl(0, 16'd8, 16'($urandom));
        readout(0, -1, -1, -1, again);
        write_smpl(0, 16'd9, 16'($urandom));
        readout(0, -1, -1, -1, again);
        write_smpl(0, 16'd10, 16'($urandom));
        readout(0, -1, -1, -1, again);

        // Pending strobe at R3.
        write_smpl(0, 16'd11, 16'($urandom));
        readout(0, 3, -1, -1, again);
        chk("pend_serviced", {31'b0, again}, 32'd1);
        readout(0, -1, -1, -1, again);

        // Two strobes in one readout: first serviced, second dropped.
        write_smpl(0, 16'($urandom), 16'($urandom));
        readout(0, 2, 5, -1, again);
        readout(0, -1, -1, -1, again);
`ifdef LPQ_OVERRUN_EN
        @(negedge clk);
        chk("overrun_set", {31'b0, ov0}, 32'd1);
`endif

        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                chk("seq_gap", {31'b0, sq0}, 32'd0);
            end
            write_smpl(0, 16'($urandom), 16'($urandom));
            s = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, D0)) : -1;
            readout(0, s, -1, -1, again);
            if (again) readout(0, -1, -1, -1, again);
        end

        set_rst(0, 1'b1);
        @(posedge clk); #1;
        set_rst(0, 1'b0);
        @(negedge clk);
        model_clear(0);
        chk("rst2_seq0", {31'b0, sq0}, 32'd0);
`ifdef LPQ_OVERRUN_EN
        chk("overrun_clr", {31'b0, ov0}, 32'd0);
`endif

        // Default depth: left = i, right = -i.
        for (int i = 1; i <= int'(D1); i++) write_smpl(1, 16'(i), 16'(-i));
        readout(1, -1, -1, -1, again);

        // Reset at R100, then a full refill is needed before the next readout.
        write_smpl(1, 16'($urandom), 16'($urandom));
        readout(1, -1, -1, 100, again);
        for (int i = 1; i < int'(D1); i++) write_smpl(1, 16'($urandom), 16'($urandom));
        write_smpl(1, 16'($urandom), 16'($urandom));
        readout(1, -1, -1, -1, again);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
